// File: rtl/sevseg_pkg.sv
// Shared types, constants and hex-to-segment decode for the seven-segment scan driver.
package sevseg_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    GUARD = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevseg_decoder.sv
// Combinational nibble-to-segment decoder with a blanking override.
module sevseg_decoder
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : hex_to_seg(nibble);

endmodule

// File: rtl/sevseg_scan_driver.sv
// Multiplexed N-digit common-anode seven-segment driver with double-buffered frame updates.
// Optional PWM dimming is enabled by defining SEVSEG_DIMMING_EN.
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 16384,
  parameter int unsigned GUARD_CYCLES = 64,
  parameter int unsigned BRIGHT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntW = $clog2(REFRESH_DIV);

  scan_state_e     state_q;
  logic [IdxW-1:0] idx_q;
  logic [CntW-1:0] cnt_q;

  logic [4*NUM_DIGITS-1:0] stage_digits_q, disp_digits_q;
  logic [NUM_DIGITS-1:0]   stage_dp_q, disp_dp_q;
  logic [NUM_DIGITS-1:0]   stage_blank_q, disp_blank_q;
  logic                    pending_q;

  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic                  frame_done_q;

  logic                  show_end, guard_end, advance, wrap;
  logic [IdxW-1:0]       idx_next;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  upper_zero;
  logic [3:0]            sel_nibble;
  logic                  sel_blank;
  logic [6:0]            dec_seg;
  logic                  pwm_on;

  assign show_end  = (state_q == SHOW) && (cnt_q == CntW'(REFRESH_DIV - 1));
  assign guard_end = (state_q == GUARD) && (cnt_q == CntW'(GUARD_CYCLES - 1));
  assign advance   = (GUARD_CYCLES == 0) ? show_end : guard_end;
  assign wrap      = advance && (idx_q == IdxW'(NUM_DIGITS - 1));
  assign idx_next  = wrap ? '0 : idx_q + 1'b1;

  // Scan FSM: each digit gets REFRESH_DIV lit cycles followed by GUARD_CYCLES dark ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SHOW;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        SHOW: begin
          if (show_end) begin
            cnt_q <= '0;
            if (GUARD_CYCLES == 0) begin
              idx_q <= idx_next;
            end else begin
              state_q <= GUARD;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GUARD: begin
          if (guard_end) begin
            cnt_q   <= '0;
            state_q <= SHOW;
            idx_q   <= idx_next;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= SHOW;
      endcase
    end
  end

  // Staging captures every load; display only changes at the frame wrap, so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_digits_q <= '0;
      stage_dp_q     <= '0;
      stage_blank_q  <= '0;
      pending_q      <= 1'b0;
      disp_digits_q  <= '0;
      disp_dp_q      <= '0;
      disp_blank_q   <= '1;
      frame_done_q   <= 1'b0;
    end else begin
      if (wrap && pending_q) begin
        disp_digits_q <= stage_digits_q;
        disp_dp_q     <= stage_dp_q;
        disp_blank_q  <= stage_blank_q;
      end
      if (load) begin
        stage_digits_q <= digits_in;
        stage_dp_q     <= dp_in;
        stage_blank_q  <= blank_in;
      end
      pending_q    <= load | (pending_q & ~wrap);
      frame_done_q <= wrap;
    end
  end

  // Digit i>0 is suppressed when it and every digit to its left hold zero.
  always_comb begin
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (disp_digits_q[4*i +: 4] == 4'h0);
      lz_mask[i] = upper_zero;
    end
  end

  assign sel_nibble = disp_digits_q[{idx_q, 2'b00} +: 4];
  assign sel_blank  = disp_blank_q[idx_q] | (lz_en & lz_mask[idx_q]);

  sevseg_decoder u_decoder (
    .nibble (sel_nibble),
    .blank  (sel_blank),
    .seg    (dec_seg)
  );

`ifdef SEVSEG_DIMMING_EN
  logic [BRIGHT_W-1:0] pwm_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  // Full-scale brightness keeps the digit lit on every PWM step.
  assign pwm_on = (brightness == '1) || (pwm_cnt_q < brightness);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pwm_on            = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= (state_q == SHOW && pwm_on) ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      seg_q <= (state_q == SHOW) ? dec_seg : SEG_BLANK;
      dp_q  <= (state_q == SHOW) ? ~disp_dp_q[idx_q] : 1'b1;
    end
  end

  assign an         = an_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign frame_done = frame_done_q;

endmodule
